// File: rtl/pipeline_scoreboard.sv
// Register scoreboard for the ID stage: per-register bubble countdown for variable-latency
// producers, issue stall on RAW/WAW hazards, busy mask and a saturating stall counter.
module pipeline_scoreboard #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LAT_W      = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rs_i,
  input  logic [REG_ADDR_W-1:0] issue_rt_i,
  input  logic                  issue_use_rs_i,
  input  logic                  issue_use_rt_i,
  input  logic                  issue_we_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [LAT_W-1:0]      issue_lat_i,
  input  logic                  issue_flush_i,
  output logic                  stall_o,
  output logic                  hazard_rs_o,
  output logic                  hazard_rt_o,
  output logic [NREG-1:0]       busy_mask_o,
  output logic [CNT_W-1:0]      stall_count_o
);

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [REG_ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
  logic                  waw, accept;

  // Out-of-range indices alias register 0, which is never busy.
  function automatic logic [REG_ADDR_W-1:0] eff_idx(input logic [REG_ADDR_W-1:0] idx);
    return (int'(idx) < int'(NREG)) ? idx : '0;
  endfunction

  assign rs_idx = eff_idx(issue_rs_i);
  assign rt_idx = eff_idx(issue_rt_i);
  assign rd_idx = eff_idx(issue_rd_i);

  always_comb begin
    hazard_rs_o = ~rst_i & issue_valid_i & issue_use_rs_i & (rs_idx != '0) &
                  (cnt_q[rs_idx] != '0);
    hazard_rt_o = ~rst_i & issue_valid_i & issue_use_rt_i & (rt_idx != '0) &
                  (cnt_q[rt_idx] != '0);
    // A younger write with shorter latency must not complete before the older one.
    waw         = ~rst_i & issue_valid_i & issue_we_i & (rd_idx != '0) &
                  (cnt_q[rd_idx] > issue_lat_i);
    stall_o     = (hazard_rs_o | hazard_rt_o | waw) & ~issue_flush_i;
    accept      = issue_valid_i & ~stall_o & ~issue_flush_i & issue_we_i &
                  (rd_idx != '0) & (issue_lat_i != '0);
  end

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        cnt_d[i] = '0;
      end else if (accept && (rd_idx == REG_ADDR_W'(i))) begin
        cnt_d[i] = issue_lat_i;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_o && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREG); i++) begin
        cnt_q[i] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      busy_mask_o[i] = (cnt_q[i] != '0);
    end
  end

  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: cycle-by-cycle vector table plus reset sequences.
// A second instance with a 2-bit stall counter shares the stimulus to exercise saturation.
module tb_pipeline_scoreboard;

  logic        clk, rst;
  logic        v, urs, urt, we, fl;
  logic [4:0]  rs, rt, rd;
  logic [2:0]  lat;
  logic        stall, hrs, hrt, s_stall, s_hrs, s_hrt;
  logic [31:0] busy, s_busy;
  logic [15:0] sc;
  logic [1:0]  s_sc;

  int n_cmp  = 0;
  int n_fail = 0;

  pipeline_scoreboard u_dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(v), .issue_rs_i(rs), .issue_rt_i(rt),
    .issue_use_rs_i(urs), .issue_use_rt_i(urt), .issue_we_i(we), .issue_rd_i(rd),
    .issue_lat_i(lat), .issue_flush_i(fl), .stall_o(stall), .hazard_rs_o(hrs),
    .hazard_rt_o(hrt), .busy_mask_o(busy), .stall_count_o(sc)
  );

  pipeline_scoreboard #(.CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(v), .issue_rs_i(rs), .issue_rt_i(rt),
    .issue_use_rs_i(urs), .issue_use_rt_i(urt), .issue_we_i(we), .issue_rd_i(rd),
    .issue_lat_i(lat), .issue_flush_i(fl), .stall_o(s_stall), .hazard_rs_o(s_hrs),
    .hazard_rt_o(s_hrt), .busy_mask_o(s_busy), .stall_count_o(s_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, urs, urt, we, fl;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  lat;
    logic        st, hrs, hrt;
    logic [31:0] busy;
    int          sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v_, logic [4:0] rs_, logic [4:0] rt_, logic urs_, logic urt_,
                              logic we_, logic [4:0] rd_, logic [2:0] lat_, logic fl_,
                              logic st_, logic hrs_, logic hrt_, logic [31:0] busy_, int sc_);
    vec_t r;
    r.v = v_; r.rs = rs_; r.rt = rt_; r.urs = urs_; r.urt = urt_; r.we = we_; r.rd = rd_;
    r.lat = lat_; r.fl = fl_; r.st = st_; r.hrs = hrs_; r.hrt = hrt_; r.busy = busy_; r.sc = sc_;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    v = r.v; rs = r.rs; rt = r.rt; urs = r.urs; urt = r.urt;
    we = r.we; rd = r.rd; lat = r.lat; fl = r.fl;
  endtask

  task automatic idle_inputs();
    v = 0; rs = 0; rt = 0; urs = 0; urt = 0; we = 0; rd = 0; lat = 0; fl = 0;
  endtask

  initial begin
    // Load-use, lat 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 5, 1, 0,  0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 1, 6, 0, 0,  1, 1, 0, 32'h20,  0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 1, 6, 0, 0,  0, 0, 0, 32'h0,   1));
    // Mul chain, lat 3 on rt
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 7, 3, 0,  0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(1, 0, 7, 0, 1, 1, 8, 0, 0,  1, 0, 1, 32'h80,  1));
    tbl.push_back(mk(1, 0, 7, 0, 1, 1, 8, 0, 0,  1, 0, 1, 32'h80,  2));
    tbl.push_back(mk(1, 0, 7, 0, 1, 1, 8, 0, 0,  1, 0, 1, 32'h80,  3));
    tbl.push_back(mk(1, 0, 7, 0, 1, 1, 8, 0, 0,  0, 0, 0, 32'h0,   4));
    // r0 and forwardable producers are never recorded
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 7, 0,  0, 0, 0, 32'h0,   4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0,  0, 0, 0, 32'h0,   4));
    tbl.push_back(mk(1, 0, 9, 1, 1, 0, 0, 0, 0,  0, 0, 0, 32'h0,   4));
    // WAW: rd4 lat5 then rd4 lat1 stalls until cnt4 <= 1
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 5, 0,  0, 0, 0, 32'h0,   4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0,  1, 0, 0, 32'h10,  4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0,  1, 0, 0, 32'h10,  5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0,  1, 0, 0, 32'h10,  6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0,  1, 0, 0, 32'h10,  7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0,  0, 0, 0, 32'h10,  8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h10,  8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   8));
    // Flushed WAW: no stall, no record; cnt4 keeps counting 5,4,3,...
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 5, 0,  0, 0, 0, 32'h0,   8));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 1,  0, 0, 0, 32'h10,  8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h10,  8));
    tbl.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 32'h10,  8));
    tbl.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 32'h10,  9));
    tbl.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 32'h10, 10));
    tbl.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,  11));
    // Both sources on the same busy register
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 10, 2, 0, 0, 0, 0, 32'h0,  11));
    tbl.push_back(mk(1, 10, 10, 1, 1, 0, 0, 0, 0, 1, 1, 1, 32'h400, 11));
    tbl.push_back(mk(1, 10, 10, 0, 1, 0, 0, 0, 0, 1, 0, 1, 32'h400, 12));
    tbl.push_back(mk(1, 10, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,  13));

    // Asynchronous reset with random inputs, before any clock edge
    rst = 0;
    v = 1'($urandom); rs = 5'($urandom); rt = 5'($urandom); urs = 1'($urandom);
    urt = 1'($urandom); we = 1'($urandom); rd = 5'($urandom); lat = 3'($urandom);
    fl = 1'($urandom);
    #1 rst = 1;
    #1;
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_busy", busy, 32'h0);
    chk("reset_count", 32'(sc), 32'h0);
    chk("reset_sat_count", 32'(s_sc), 32'h0);
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();

    foreach (tbl[k]) begin
      drive(tbl[k]);
      #1;
      chk($sformatf("row%0d_stall", k), 32'(stall), 32'(tbl[k].st));
      chk($sformatf("row%0d_hrs", k), 32'(hrs), 32'(tbl[k].hrs));
      chk($sformatf("row%0d_hrt", k), 32'(hrt), 32'(tbl[k].hrt));
      chk($sformatf("row%0d_busy", k), busy, tbl[k].busy);
      chk($sformatf("row%0d_count", k), 32'(sc), 32'(tbl[k].sc));
      chk($sformatf("row%0d_sat_count", k), 32'(s_sc), (tbl[k].sc > 3) ? 32'd3 : 32'(tbl[k].sc));
      @(posedge clk); #1;
    end

    // Reset in the middle of a long countdown
    idle_inputs();
    v = 1; we = 1; rd = 12; lat = 7;
    @(posedge clk); #1;
    idle_inputs();
    v = 1; rs = 12; urs = 1;
    #1;
    chk("midrst_pre_stall", 32'(stall), 32'h1);
    chk("midrst_pre_busy", busy, 32'h1000);
    rst = 1;
    #1;
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_hrs", 32'(hrs), 32'h0);
    chk("midrst_busy", busy, 32'h0);
    chk("midrst_count", 32'(sc), 32'h0);
    chk("midrst_sat_count", 32'(s_sc), 32'h0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("post_rst_stall", 32'(stall), 32'h0);
    chk("post_rst_busy", busy, 32'h0);
    @(posedge clk); #1;
    chk("post_rst_count", 32'(sc), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
